// File: rtl/register_file_mp_pkg.sv
// Shared constants, lane-winner payload and lane helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned LANE_WIDTH = 8;
    localparam int unsigned MAX_PORTS  = 16;
    localparam int unsigned PORT_IDW   = 4;

    typedef struct packed {
        logic                valid;
        logic [PORT_IDW-1:0] port;
    } lane_win_t;

    function automatic logic [LANE_WIDTH-1:0] lane_merge(
        input logic [LANE_WIDTH-1:0] old_lane,
        input logic [LANE_WIDTH-1:0] new_lane,
        input logic                  mask
    );
        return mask ? new_lane : old_lane;
    endfunction

    // Highest-index requesting port wins the lane.
    function automatic lane_win_t prio_resolve(input logic [MAX_PORTS-1:0] hits);
        lane_win_t win;
        win = '0;
        for (int unsigned k = 0; k < MAX_PORTS; k++) begin
            if (hits[k]) begin
                win.valid = 1'b1;
                win.port  = PORT_IDW'(k);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between issue/writeback logic (master) and the register file (slave).
interface register_file_mp_if #(
    parameter int unsigned NUM_REGISTERS = 8,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NUM_READ      = 3,
    parameter int unsigned NUM_WRITE     = 2
);
    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned IDW   = $clog2(NUM_REGISTERS);

    logic [NUM_WRITE-1:0]                      we;
    logic [NUM_WRITE-1:0][LANES-1:0]           write_lanes;
    logic [NUM_WRITE-1:0][IDW-1:0]             write_id;
    logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]      write_data;
    logic [NUM_WRITE-1:0]                      write_release;
    logic                                      reserve;
    logic [IDW-1:0]                            reserve_id;
    logic [NUM_READ-1:0][IDW-1:0]              read_id;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]       read_data;
    logic [NUM_READ-1:0]                       read_busy;
    logic [NUM_REGISTERS-1:0]                  busy;
    logic                                      double_reserve;
    logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0]  registers;

    modport master (
        output we, write_lanes, write_id, write_data, write_release,
        output reserve, reserve_id, read_id,
        input  read_data, read_busy, busy, double_reserve, registers
    );

    modport slave (
        input  we, write_lanes, write_id, write_data, write_release,
        input  reserve, reserve_id, read_id,
        output read_data, read_busy, busy, double_reserve, registers
    );

endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy scoreboard: reserve at issue, release at writeback.
module regfile_scoreboard #(
    parameter int unsigned NUM_REGISTERS = 8,
    parameter int unsigned NUM_READ      = 3,
    parameter int unsigned NUM_WRITE     = 2,
    parameter int unsigned BYPASS        = 1,
    localparam int unsigned IDW          = $clog2(NUM_REGISTERS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WRITE-1:0]           we_i,
    input  logic [NUM_WRITE-1:0]           write_release_i,
    input  logic [NUM_WRITE-1:0][IDW-1:0]  write_id_i,
    input  logic                           reserve_i,
    input  logic [IDW-1:0]                 reserve_id_i,
    input  logic [NUM_READ-1:0][IDW-1:0]   read_id_i,
    output logic [NUM_REGISTERS-1:0]       busy_o,
    output logic [NUM_READ-1:0]            read_busy_o,
    output logic                           double_reserve_o
);

    logic [NUM_REGISTERS-1:0] busy_q, busy_d;
    logic [NUM_REGISTERS-1:0] released;
    logic                     dbl_q, dbl_d;

    always_comb begin
        released = '0;
        for (int unsigned r = 0; r < NUM_REGISTERS; r++) begin
            for (int unsigned k = 0; k < NUM_WRITE; k++) begin
                if (we_i[k] && write_release_i[k] && (write_id_i[k] == IDW'(r)))
                    released[r] = 1'b1;
            end
        end
    end

    // Reserve is applied after release so a same-cycle reserve keeps the bit set.
    always_comb begin
        busy_d = busy_q & ~released;
        dbl_d  = 1'b0;
        if (reserve_i) begin
            dbl_d                = busy_q[reserve_id_i] & ~released[reserve_id_i];
            busy_d[reserve_id_i] = 1'b1;
        end
    end

    always_comb begin
        read_busy_o = '0;
        for (int unsigned j = 0; j < NUM_READ; j++) begin
            if (BYPASS != 0)
                read_busy_o[j] = busy_q[read_id_i[j]] & ~released[read_id_i[j]];
            else
                read_busy_o[j] = busy_q[read_id_i[j]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            dbl_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            dbl_q  <= dbl_d;
        end
    end

    assign busy_o           = busy_q;
    assign double_reserve_o = dbl_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port general register file: lane-masked writes with port priority, bypassed reads, busy scoreboard.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGISTERS = 8,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NUM_READ      = 3,
    parameter int unsigned NUM_WRITE     = 2,
    parameter int unsigned BYPASS        = 1
) (
    input  logic              clk,
    input  logic              reset,
    register_file_mp_if.slave bus
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned IDW   = $clog2(NUM_REGISTERS);

    logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

    // Per register and lane, pick the highest-index port writing it this cycle.
    always_comb begin : write_merge
        logic [MAX_PORTS-1:0]  hits;
        lane_win_t             win;
        logic [LANE_WIDTH-1:0] lane_new;
        regs_d   = regs_q;
        hits     = '0;
        win      = '0;
        lane_new = '0;
        for (int unsigned r = 0; r < NUM_REGISTERS; r++) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                hits = '0;
                for (int unsigned k = 0; k < NUM_WRITE; k++)
                    hits[k] = bus.we[k] & bus.write_lanes[k][l] & (bus.write_id[k] == IDW'(r));
                win      = prio_resolve(hits);
                lane_new = '0;
                for (int unsigned k = 0; k < NUM_WRITE; k++) begin
                    if (win.port == PORT_IDW'(k))
                        lane_new = bus.write_data[k][l*LANE_WIDTH +: LANE_WIDTH];
                end
                regs_d[r][l*LANE_WIDTH +: LANE_WIDTH] =
                    lane_merge(regs_q[r][l*LANE_WIDTH +: LANE_WIDTH], lane_new, win.valid);
            end
        end
    end

    // Reads use the same lane-winner rule as the write path when forwarding.
    always_comb begin : read_path
        logic [MAX_PORTS-1:0]  hits;
        lane_win_t             win;
        logic [LANE_WIDTH-1:0] lane_new;
        logic [DATA_WIDTH-1:0] stored;
        bus.read_data = '0;
        hits          = '0;
        win           = '0;
        lane_new      = '0;
        stored        = '0;
        for (int unsigned j = 0; j < NUM_READ; j++) begin
            stored = regs_q[bus.read_id[j]];
            for (int unsigned l = 0; l < LANES; l++) begin
                hits = '0;
                for (int unsigned k = 0; k < NUM_WRITE; k++)
                    hits[k] = bus.we[k] & bus.write_lanes[k][l] & (bus.write_id[k] == bus.read_id[j]);
                win      = prio_resolve(hits);
                lane_new = '0;
                for (int unsigned k = 0; k < NUM_WRITE; k++) begin
                    if (win.port == PORT_IDW'(k))
                        lane_new = bus.write_data[k][l*LANE_WIDTH +: LANE_WIDTH];
                end
                bus.read_data[j][l*LANE_WIDTH +: LANE_WIDTH] =
                    lane_merge(stored[l*LANE_WIDTH +: LANE_WIDTH], lane_new,
                               win.valid && (BYPASS != 0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    assign bus.registers = regs_q;

    regfile_scoreboard #(
        .NUM_REGISTERS (NUM_REGISTERS),
        .NUM_READ      (NUM_READ),
        .NUM_WRITE     (NUM_WRITE),
        .BYPASS        (BYPASS)
    ) u_scoreboard (
        .clk              (clk),
        .reset            (reset),
        .we_i             (bus.we),
        .write_release_i  (bus.write_release),
        .write_id_i       (bus.write_id),
        .reserve_i        (bus.reserve),
        .reserve_id_i     (bus.reserve_id),
        .read_id_i        (bus.read_id),
        .busy_o           (bus.busy),
        .read_busy_o      (bus.read_busy),
        .double_reserve_o (bus.double_reserve)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one bypassing and one non-bypassing instance fed the same stimulus.
module tb_register_file_mp;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_file_mp_if rf_if ();
    register_file_mp_if rf_nb ();

    assign rf_nb.we            = rf_if.we;
    assign rf_nb.write_lanes   = rf_if.write_lanes;
    assign rf_nb.write_id      = rf_if.write_id;
    assign rf_nb.write_data    = rf_if.write_data;
    assign rf_nb.write_release = rf_if.write_release;
    assign rf_nb.reserve       = rf_if.reserve;
    assign rf_nb.reserve_id    = rf_if.reserve_id;
    assign rf_nb.read_id       = rf_if.read_id;

    register_file_mp #(.BYPASS(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf_if)
    );

    register_file_mp #(.BYPASS(0)) u_dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (rf_nb)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        rf_if.we            = '0;
        rf_if.write_lanes   = '0;
        rf_if.write_id      = '0;
        rf_if.write_data    = '0;
        rf_if.write_release = '0;
        rf_if.reserve       = 1'b0;
        rf_if.reserve_id    = '0;
        rf_if.read_id       = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int port, input logic [2:0] id, input logic [1:0] lanes,
                      input logic [15:0] data, input logic rel);
        rf_if.we[port]            = 1'b1;
        rf_if.write_id[port]      = id;
        rf_if.write_lanes[port]   = lanes;
        rf_if.write_data[port]    = data;
        rf_if.write_release[port] = rel;
    endtask

    task automatic check_cleared(input string tag);
        for (int r = 0; r < 8; r++) begin
            check($sformatf("%s_reg%0d", tag, r), 32'(rf_if.registers[r]), 32'h0);
            check($sformatf("%s_nb_reg%0d", tag, r), 32'(rf_nb.registers[r]), 32'h0);
        end
        check({tag, "_busy"}, 32'(rf_if.busy), 32'h0);
        check({tag, "_dbl"}, 32'(rf_if.double_reserve), 32'h0);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state and reads of every id
        check_cleared("rst");
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 3; j++) rf_if.read_id[j] = 3'((b * 3 + j) % 8);
            #1;
            for (int j = 0; j < 3; j++)
                check($sformatf("rst_rd_b%0d_p%0d", b, j), 32'(rf_if.read_data[j]), 32'h0);
        end

        // Lane-masked writes on port 0 (legacy 11/01/10 behaviour)
        idle(); wr(0, 3'd3, 2'b11, 16'h1234, 1'b0); step();
        check("r3_full", 32'(rf_if.registers[3]), 32'h1234);
        idle(); wr(0, 3'd3, 2'b01, 16'h00AB, 1'b0); step();
        check("r3_low", 32'(rf_if.registers[3]), 32'h12AB);
        idle(); wr(0, 3'd3, 2'b10, 16'hCD00, 1'b0); step();
        check("r3_high", 32'(rf_if.registers[3]), 32'hCDAB);
        idle(); wr(0, 3'd3, 2'b00, 16'hFFFF, 1'b0); step();
        check("r3_nolane", 32'(rf_if.registers[3]), 32'hCDAB);

        // Two ports, different lanes of one register; bypass vs stored read
        idle();
        wr(0, 3'd5, 2'b11, 16'h1111, 1'b0);
        wr(1, 3'd5, 2'b10, 16'h2200, 1'b0);
        rf_if.read_id[0] = 3'd5;
        #1;
        check("r5_byp_rd", 32'(rf_if.read_data[0]), 32'h2211);
        check("r5_nb_rd_old", 32'(rf_nb.read_data[0]), 32'h0000);
        step();
        idle();
        rf_if.read_id[0] = 3'd5;
        #1;
        check("r5_reg", 32'(rf_if.registers[5]), 32'h2211);
        check("r5_nb_rd_new", 32'(rf_nb.read_data[0]), 32'h2211);

        // Same lane on both ports: port 1 wins lane 0
        idle();
        wr(0, 3'd6, 2'b11, 16'hAAAA, 1'b0);
        wr(1, 3'd6, 2'b01, 16'h00BB, 1'b0);
        rf_if.read_id[1] = 3'd6;
        #1;
        check("r6_byp_rd", 32'(rf_if.read_data[1]), 32'hAABB);
        step();
        check("r6_reg", 32'(rf_if.registers[6]), 32'hAABB);

        // Reserve, then release+reserve same cycle
        idle(); rf_if.reserve = 1'b1; rf_if.reserve_id = 3'd2; step();
        check("rsv2_busy", 32'(rf_if.busy), 32'h04);
        check("rsv2_dbl", 32'(rf_if.double_reserve), 32'h0);
        idle();
        wr(1, 3'd2, 2'b11, 16'h5555, 1'b1);
        rf_if.reserve    = 1'b1;
        rf_if.reserve_id = 3'd2;
        rf_if.read_id[2] = 3'd2;
        #1;
        check("rb2_byp", 32'(rf_if.read_busy[2]), 32'h0);
        check("rb2_nb", 32'(rf_nb.read_busy[2]), 32'h1);
        step();
        check("relrsv_busy", 32'(rf_if.busy), 32'h04);
        check("relrsv_dbl", 32'(rf_if.double_reserve), 32'h0);
        check("r2_reg", 32'(rf_if.registers[2]), 32'h5555);

        // Release with no lanes, then release of a non-busy register
        idle(); wr(0, 3'd2, 2'b00, 16'h0000, 1'b1); step();
        check("rel2_busy", 32'(rf_if.busy), 32'h0);
        check("rel2_reg", 32'(rf_if.registers[2]), 32'h5555);
        idle(); wr(1, 3'd7, 2'b00, 16'h0000, 1'b1); step();
        check("rel7_busy", 32'(rf_if.busy), 32'h0);

        // Back-to-back reserve of r4
        idle(); rf_if.reserve = 1'b1; rf_if.reserve_id = 3'd4; step();
        check("rsv4a_busy", 32'(rf_if.busy), 32'h10);
        check("rsv4a_dbl", 32'(rf_if.double_reserve), 32'h0);
        step();
        check("rsv4b_busy", 32'(rf_if.busy), 32'h10);
        check("rsv4b_dbl", 32'(rf_if.double_reserve), 32'h1);
        idle(); step();
        check("rsv4c_dbl", 32'(rf_if.double_reserve), 32'h0);
        check("rsv4c_busy", 32'(rf_if.busy), 32'h10);

        // Reset during traffic drops concurrent writes and reserve
        idle();
        wr(0, 3'd1, 2'b11, 16'hFFFF, 1'b0);
        wr(1, 3'd3, 2'b11, 16'hEEEE, 1'b0);
        rf_if.reserve    = 1'b1;
        rf_if.reserve_id = 3'd1;
        reset            = 1'b1;
        step();
        reset = 1'b0;
        idle();
        check_cleared("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
